// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, sync polarities and region decode shared with the image generator
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_HS_POL   = 1'b0;
  localparam bit VGA_VS_POL   = 1'b0;
  localparam int VGA_RGB_W    = 8;
  localparam int VGA_CW       = 10;

  typedef enum logic [1:0] {
    RGN_ACTIVE,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } region_e;

  function automatic region_e region_of(input int pos, input int active, input int fp, input int sync);
    if (pos < active)                 return RGN_ACTIVE;
    else if (pos < active + fp)       return RGN_FP;
    else if (pos < active + fp + sync) return RGN_SYNC;
    else                              return RGN_BP;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-rate enable, colour input and video timing outputs of the generator
interface vga_timing_gen_if #(
  parameter int RGB_W = 8,
  parameter int CW    = 10
);
  logic             pix_en;
  logic [RGB_W-1:0] i_rgb;
  logic [CW-1:0]    h;
  logic [CW-1:0]    v;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [RGB_W-1:0] o_rgb;
  logic             sol;
  logic             sof;
  logic [7:0]       frame_cnt;

  modport master (
    input  pix_en, i_rgb,
    output h, v, hsync, vsync, de, o_rgb, sol, sof, frame_cnt
  );

  modport slave (
    output pix_en, i_rgb,
    input  h, v, hsync, vsync, de, o_rgb, sol, sof, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter for one axis with terminal count and region decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc,
  output region_e       region
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_zero
    $error("vga_axis_counter: timing parameters must be non-zero");
  end
  if (TOTAL > (2 ** CW)) begin : g_bad_width
    $error("vga_axis_counter: CW too narrow for the axis total");
  end

  assign tc = (int'(cnt) == TOTAL - 1);

  always_comb begin
    region = region_of(int'(cnt), ACTIVE, FP, SYNC);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: h/v counters, registered syncs, data enable, colour gating and strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL,
  parameter int RGB_W    = VGA_RGB_W,
  parameter int CW       = VGA_CW
) (
  input  logic             clk,
  input  logic             clr_n,
  vga_timing_gen_if.master vif
);

  localparam logic HS_ON = HS_POL;
  localparam logic VS_ON = VS_POL;

  logic [CW-1:0]    h, v;
  logic             h_tc, v_tc;
  region_e          h_rgn, v_rgn;
  logic             visible;
  logic             hsync_q, vsync_q, de_q, sol_q, sof_q;
  logic [RGB_W-1:0] rgb_q;
  logic [7:0]       frame_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h (
    .clk(clk), .clr_n(clr_n), .en(vif.pix_en),
    .cnt(h), .tc(h_tc), .region(h_rgn)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v (
    .clk(clk), .clr_n(clr_n), .en(vif.pix_en && h_tc),
    .cnt(v), .tc(v_tc), .region(v_rgn)
  );

  assign visible = (h_rgn == RGN_ACTIVE) && (v_rgn == RGN_ACTIVE);

  // Strobes are re-evaluated every clk so they stay one clk wide even when
  // pix_en is slower than clk; everything else advances only on pix_en.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      sol_q <= vif.pix_en && (h == '0);
      sof_q <= vif.pix_en && (h == '0) && (v == '0);
      if (vif.pix_en) begin
        hsync_q <= (h_rgn == RGN_SYNC) ? HS_ON : ~HS_ON;
        vsync_q <= (v_rgn == RGN_SYNC) ? VS_ON : ~VS_ON;
        de_q    <= visible;
        rgb_q   <= visible ? vif.i_rgb : '0;
        if (h_tc && v_tc) begin
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  assign vif.h         = h;
  assign vif.v         = v;
  assign vif.hsync     = hsync_q;
  assign vif.vsync     = vsync_q;
  assign vif.de        = de_q;
  assign vif.o_rgb     = rgb_q;
  assign vif.sol       = sol_q;
  assign vif.sof       = sof_q;
  assign vif.frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen: default 640x480 line timing and an 8x6 frame instance
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.RGB_W(8), .CW(10)) vd ();
  vga_timing_gen_if #(.RGB_W(8), .CW(4))  vsi ();

  vga_timing_gen dut (
    .clk(clk), .clr_n(clr_n), .vif(vd)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(8), .CW(4)
  ) dut_s (
    .clk(clk), .clr_n(clr_n), .vif(vsi)
  );

  typedef struct {
    int k;
    int h, v, hs, vs, de, rgb, sol, sof, fc;
  } vec_t;

  vec_t tv_d[12];
  vec_t tv_s[16];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t e, input int h, input int v,
                           input int hs, input int vs, input int de, input int rgb,
                           input int sol, input int sof, input int fc);
    check($sformatf("%s k=%0d h", tag, e.k), h, e.h);
    check($sformatf("%s k=%0d v", tag, e.k), v, e.v);
    check($sformatf("%s k=%0d hsync", tag, e.k), hs, e.hs);
    check($sformatf("%s k=%0d vsync", tag, e.k), vs, e.vs);
    check($sformatf("%s k=%0d de", tag, e.k), de, e.de);
    check($sformatf("%s k=%0d o_rgb", tag, e.k), rgb, e.rgb);
    check($sformatf("%s k=%0d sol", tag, e.k), sol, e.sol);
    check($sformatf("%s k=%0d sof", tag, e.k), sof, e.sof);
    check($sformatf("%s k=%0d frame_cnt", tag, e.k), fc, e.fc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int de_cnt, hs_lo, sol_cnt, rgb_err, sof_cnt;
    int hold_err, h_err, en_ticks, sol_clk, sof_clk, hs_clk, de_clk;
    logic [9:0] ph, pv;
    logic       phs, pvs, pde;
    logic [7:0] prgb;

    //              k     h    v  hs vs de rgb   sol sof fc
    tv_d[0]  = '{0,     0,   0, 1, 1, 0, 0,    0, 0, 0};
    tv_d[1]  = '{1,     1,   0, 1, 1, 1, 255,  1, 1, 0};
    tv_d[2]  = '{2,     2,   0, 1, 1, 1, 255,  0, 0, 0};
    tv_d[3]  = '{640, 640,   0, 1, 1, 1, 255,  0, 0, 0};
    tv_d[4]  = '{641, 641,   0, 1, 1, 0, 0,    0, 0, 0};
    tv_d[5]  = '{656, 656,   0, 1, 1, 0, 0,    0, 0, 0};
    tv_d[6]  = '{657, 657,   0, 0, 1, 0, 0,    0, 0, 0};
    tv_d[7]  = '{752, 752,   0, 0, 1, 0, 0,    0, 0, 0};
    tv_d[8]  = '{753, 753,   0, 1, 1, 0, 0,    0, 0, 0};
    tv_d[9]  = '{799, 799,   0, 1, 1, 0, 0,    0, 0, 0};
    tv_d[10] = '{800,   0,   1, 1, 1, 0, 0,    0, 0, 0};
    tv_d[11] = '{801,   1,   1, 1, 1, 1, 255,  1, 0, 0};

    tv_s[0]  = '{0,     0, 0, 0, 0, 0, 0,    0, 0, 0};
    tv_s[1]  = '{1,     1, 0, 0, 0, 1, 'h5A, 1, 1, 0};
    tv_s[2]  = '{4,     4, 0, 0, 0, 1, 'h5A, 0, 0, 0};
    tv_s[3]  = '{5,     5, 0, 0, 0, 0, 0,    0, 0, 0};
    tv_s[4]  = '{6,     6, 0, 1, 0, 0, 0,    0, 0, 0};
    tv_s[5]  = '{7,     7, 0, 1, 0, 0, 0,    0, 0, 0};
    tv_s[6]  = '{8,     0, 1, 0, 0, 0, 0,    0, 0, 0};
    tv_s[7]  = '{9,     1, 1, 0, 0, 1, 'h5A, 1, 0, 0};
    tv_s[8]  = '{32,    0, 4, 0, 0, 0, 0,    0, 0, 0};
    tv_s[9]  = '{33,    1, 4, 0, 1, 0, 0,    1, 0, 0};
    tv_s[10] = '{40,    0, 5, 0, 1, 0, 0,    0, 0, 0};
    tv_s[11] = '{41,    1, 5, 0, 0, 0, 0,    1, 0, 0};
    tv_s[12] = '{48,    0, 0, 0, 0, 0, 0,    0, 0, 1};
    tv_s[13] = '{49,    1, 0, 0, 0, 1, 'h5A, 1, 1, 1};
    tv_s[14] = '{12240, 0, 0, 0, 0, 0, 0,    0, 0, 255};
    tv_s[15] = '{12288, 0, 0, 0, 0, 0, 0,    0, 0, 0};

    clr_n = 1'b0;
    vd.pix_en = 1'b0;   vd.i_rgb = 8'hFF;
    vsi.pix_en = 1'b0;  vsi.i_rgb = 8'h5A;
    repeat (3) step();
    check("small reset hsync", int'(vsi.hsync), 0);
    check("small reset vsync", int'(vsi.vsync), 0);

    // Default instance, pix_en tied high, first line and a bit.
    clr_n = 1'b1;
    vd.pix_en = 1'b1;
    k = 0;
    de_cnt = 0; hs_lo = 0; sol_cnt = 0; rgb_err = 0;
    for (int i = 0; i < 12; i++) begin
      while (k < tv_d[i].k) begin
        step();
        k++;
        if (k <= 800) begin
          if (vd.de) de_cnt++;
          if (!vd.hsync) hs_lo++;
          if (vd.sol) sol_cnt++;
        end
        if (vd.o_rgb !== (vd.de ? 8'hFF : 8'h00)) rgb_err++;
      end
      check_vec("dflt", tv_d[i], int'(vd.h), int'(vd.v), int'(vd.hsync), int'(vd.vsync),
                int'(vd.de), int'(vd.o_rgb), int'(vd.sol), int'(vd.sof), int'(vd.frame_cnt));
    end
    check("line de ticks", de_cnt, 640);
    check("line hsync low ticks", hs_lo, 96);
    check("line sol strobes", sol_cnt, 1);
    check("rgb gated by de", rgb_err, 0);

    // Asynchronous reset in the middle of the frame, no clock edge needed.
    clr_n = 1'b0;
    #1;
    check("async rst h", int'(vd.h), 0);
    check("async rst v", int'(vd.v), 0);
    check("async rst de", int'(vd.de), 0);
    check("async rst sol", int'(vd.sol), 0);
    check("async rst o_rgb", int'(vd.o_rgb), 0);
    step();
    step();
    clr_n = 1'b1;

    // pix_en every second clk: hold on disabled cycles, one-clk strobes.
    hold_err = 0; h_err = 0; en_ticks = 0;
    sol_clk = 0; sof_clk = 0; hs_clk = 0; de_clk = 0; rgb_err = 0;
    for (int c = 0; c < 1700; c++) begin
      vd.pix_en = ((c % 2) == 0);
      ph = vd.h; pv = vd.v; phs = vd.hsync; pvs = vd.vsync; pde = vd.de; prgb = vd.o_rgb;
      step();
      if (vd.pix_en) begin
        en_ticks++;
        if (int'(vd.h) != (en_ticks % 800)) h_err++;
      end else begin
        if (vd.h !== ph || vd.v !== pv || vd.hsync !== phs || vd.vsync !== pvs ||
            vd.de !== pde || vd.o_rgb !== prgb || vd.sol !== 1'b0 || vd.sof !== 1'b0)
          hold_err++;
      end
      if (vd.sol) sol_clk++;
      if (vd.sof) sof_clk++;
      if (!vd.hsync) hs_clk++;
      if (vd.de) de_clk++;
      if (vd.o_rgb !== (vd.de ? 8'hFF : 8'h00)) rgb_err++;
    end
    check("half-rate h tracking", h_err, 0);
    check("half-rate hold", hold_err, 0);
    check("half-rate sol clks", sol_clk, 2);
    check("half-rate sof clks", sof_clk, 1);
    check("half-rate hsync low clks", hs_clk, 192);
    check("half-rate de clks", de_clk, 1380);
    check("half-rate rgb gated", rgb_err, 0);

    // Small 8x6 instance, full frames through the frame counter wrap.
    vd.pix_en = 1'b0;
    vsi.pix_en = 1'b1;
    k = 0; sof_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while (k < tv_s[i].k) begin
        step();
        k++;
        if (vsi.sof) sof_cnt++;
      end
      check_vec("small", tv_s[i], int'(vsi.h), int'(vsi.v), int'(vsi.hsync), int'(vsi.vsync),
                int'(vsi.de), int'(vsi.o_rgb), int'(vsi.sol), int'(vsi.sof), int'(vsi.frame_cnt));
    end
    check("small sof per 256 frames", sof_cnt, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
